add_tree_acc: RTL and testbench
===============================

// Module: add_tree_acc
// PURPOSE
//  Pipelined, parametrised N-input adder tree with valid handshake and optional multi-beat accumulation.
//  Sums NUMBER_INPUT packed operands per beat, then either emits the sum or accumulates it over a beat group.
//  Saturates to BIT_OUTPUT and reports a sticky overflow flag and beat count per group.
//  Intended to follow MAC/PE arrays as the partial-sum reduction and accumulation stage.
// PARAMETERS
//  NUMBER_INPUT  4   number of operands per beat (>=1)
//  BIT_INPUT     21  width of each operand
//  BIT_OUTPUT    28  width of out; saturation bound
//  SIGNED        0   0: unsigned operands/result; 1: two's complement
//  CNT_W         8   width of out_beats
// PORTS
//  clk        in   1                     rising-edge clock
//  rst        in   1                     synchronous, active-high reset
//  in_valid   in   1                     beat present on in/acc_en/in_last
//  in         in   NUMBER_INPUT*BIT_INPUT operand i at in[i*BIT_INPUT +: BIT_INPUT]
//  acc_en     in   1                     1: beat joins accumulation group; 0: standalone beat
//  in_last    in   1                     closes the group (used only when acc_en=1)
//  out_valid  out  1                     one-cycle pulse: out/out_ovf/out_beats valid
//  out        out  BIT_OUTPUT            saturated sum/accumulation result
//  out_ovf    out  1                     saturation occurred anywhere in the reported group
//  out_beats  out  CNT_W                 beats in the reported group (saturates at 2^CNT_W-1)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all pipeline valids, accumulator, group state, out, out_valid, out_ovf, out_beats <= 0.
//    Reset mid-group discards the group and any in-flight beats; no output is produced for them.
//  - No backpressure: a beat is accepted every cycle that in_valid=1; in_valid=0 cycles are bubbles.
//  - Tree: L = max(1, clog2(NUMBER_INPUT)) levels. Each level adds adjacent pairs; an odd leftover passes through.
//    Each level is registered. Width grows by 1 per level (BIT_INPUT+L at the root).
//    Operands are sign-extended (SIGNED=1) or zero-extended (SIGNED=0). Full precision, no truncation in the tree.
//  - acc_en, in_last and valid are pipelined alongside the data through all L levels.
//  - Accumulator stage (1 registered stage). Latency is in_valid -> out_valid = L+1 cycles. Throughput is 1 beat/cycle.
//  - Accumulator stage, for each arriving valid beat with tree sum S:
//      base = group_open ? acc : 0
//      r = sat(base + S), computed at full precision, then clamped.
//      Unsigned range: [0, 2^BIT_OUTPUT-1]. Signed range: [-2^(BIT_OUTPUT-1), 2^(BIT_OUTPUT-1)-1].
//      ovf_g = (group_open ? ovf_acc : 0) | clamped; beats_g = sat_cnt((group_open ? cnt : 0) + 1).
//      If acc_en=0, or in_last=1, the beat closes the group:
//        out <= r, out_ovf <= ovf_g, out_beats <= beats_g, out_valid <= 1.
//        group_open <= 0; acc, ovf_acc and cnt <= 0.
//      Otherwise: acc <= r, ovf_acc <= ovf_g, cnt <= beats_g, group_open <= 1, out_valid <= 0.
//  - Group state machine: IDLE (group_open=0) -> OPEN on an acc_en=1, in_last=0 beat.
//    OPEN -> IDLE on any closing beat. A standalone acc_en=0 beat arriving while OPEN is included and closes the group.
//  - A group of one beat (acc_en=1, in_last=1, while IDLE) behaves like a standalone beat.
//  - Bubbles while OPEN hold acc/cnt/ovf unchanged; the group stays open indefinitely.
//  - out, out_ovf, out_beats hold their last value while out_valid=0. out_valid is never high two cycles
//    unless two consecutive beats close groups.
//  - Saturation is applied after every add, so an accumulator that has clamped stays at the bound until the group closes.
// TESTING (N=4, BIT_INPUT=8, BIT_OUTPUT=12, CNT_W=8; L=2, latency 3)
//  1. SIGNED=0, one beat in={1,2,3,4}, acc_en=0 -> 3 cycles later one out_valid pulse; out=10, out_beats=1, out_ovf=0.
//  2. SIGNED=0, 4 back-to-back beats of all-255 (S=1020), acc_en=1, in_last on 4th
//     -> single pulse; out=4080, out_beats=4, out_ovf=0.
//     Same with 5 beats -> out=4095, out_beats=5, out_ovf=1.
//  3. Test 2 with in_valid=0 bubbles between beats -> identical result. Pulse occurs 3 cycles after the last beat.
//  4. SIGNED=1, 5 beats of all -128 (S=-512) grouped -> out=-2048 (0x800), out_ovf=1, out_beats=5.
//     1 beat {-128,127,1,0} -> out=0.
//  5. Open group with 2 beats, assert rst 1 cycle, then a standalone beat {1,1,1,1}
//     -> no output for the aborted group; out=4, out_beats=1.
//  6. Open group (acc_en=1) of 2 beats of {1,1,1,1}, then an acc_en=0 beat {2,2,2,2}
//     -> one pulse; out=16, out_beats=3, and the next beat starts a fresh group.

Source files
------------

// File: rtl/add_tree_acc_if.sv
// add_tree_acc_if: beat input (in_valid/in/acc_en/in_last) and result output (out_valid/out/out_ovf/out_beats) bundle
interface add_tree_acc_if #(
  parameter int NUMBER_INPUT = 4,
  parameter int BIT_INPUT = 21,
  parameter int BIT_OUTPUT = 28,
  parameter int CNT_W = 8
);
  logic in_valid;
  logic [NUMBER_INPUT*BIT_INPUT-1:0] in;
  logic acc_en;
  logic in_last;
  logic out_valid;
  logic [BIT_OUTPUT-1:0] out;
  logic out_ovf;
  logic [CNT_W-1:0] out_beats;
  modport master (output in_valid, in, acc_en, in_last, input out_valid, out, out_ovf, out_beats);
  modport slave (input in_valid, in, acc_en, in_last, output out_valid, out, out_ovf, out_beats);
endinterface

// File: rtl/add_tree_acc.sv
// add_tree_acc: pipelined N-input adder tree with saturating multi-beat accumulation; ports clk, rst, bus (add_tree_acc_if.slave)
module add_tree_acc #(
  parameter int NUMBER_INPUT = 4,
  parameter int BIT_INPUT = 21,
  parameter int BIT_OUTPUT = 28,
  parameter bit SIGNED = 0,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  add_tree_acc_if.slave bus
);
  localparam int L = NUMBER_INPUT > 1 ? $clog2(NUMBER_INPUT) : 1;
  localparam int P = 1 << L;
  localparam int W = BIT_INPUT + L;
  localparam int F = (W > BIT_OUTPUT ? W : BIT_OUTPUT) + 2;
  localparam logic [F-1:0] HI = SIGNED ? {{(F-BIT_OUTPUT+1){1'b0}}, {(BIT_OUTPUT-1){1'b1}}}
                                       : {{(F-BIT_OUTPUT){1'b0}}, {BIT_OUTPUT{1'b1}}};
  localparam logic [F-1:0] LO = SIGNED ? {{(F-BIT_OUTPUT+1){1'b1}}, {(BIT_OUTPUT-1){1'b0}}} : '0;
  typedef enum logic {IDLE, OPEN} state_t;
  state_t state, state_n;
  logic [P-1:0][W-1:0] ext, cur;
  logic [L:1][P-1:0][W-1:0] d, q;
  logic [L:1] v, ae, lst;
  logic [W-1:0] s;
  logic [BIT_OUTPUT-1:0] acc, base, r;
  logic signed [F-1:0] sum;
  logic [CNT_W-1:0] cnt, base_cnt, beats_g;
  logic ovf_acc, ovf_g, over, under, open, close;
  always_comb begin
    ext = '0;
    for (int i = 0; i < NUMBER_INPUT; i++)
      ext[i] = {{L{SIGNED & bus.in[i*BIT_INPUT+BIT_INPUT-1]}}, bus.in[i*BIT_INPUT +: BIT_INPUT]};
    d = '0;
    cur = ext;
    for (int l = 1; l <= L; l++) begin
      for (int i = 0; i < P/2; i++)
        d[l][i] = cur[2*i] + cur[2*i+1];
      cur = q[l];
    end
  end
  always_ff @(posedge clk) begin
    q <= d;
    v[1] <= rst ? 1'b0 : bus.in_valid;
    ae[1] <= bus.acc_en;
    lst[1] <= bus.in_last;
    for (int l = 2; l <= L; l++) begin
      v[l] <= rst ? 1'b0 : v[l-1];
      ae[l] <= ae[l-1];
      lst[l] <= lst[l-1];
    end
  end
  always_comb begin
    s = q[L][0];
    open = state == OPEN;
    base = open ? acc : '0;
    sum = {{(F-W){SIGNED & s[W-1]}}, s} + {{(F-BIT_OUTPUT){SIGNED & base[BIT_OUTPUT-1]}}, base};
    over = sum > $signed(HI);
    under = sum < $signed(LO);
    r = over ? HI[BIT_OUTPUT-1:0] : under ? LO[BIT_OUTPUT-1:0] : sum[BIT_OUTPUT-1:0];
    ovf_g = (open & ovf_acc) | over | under;
    base_cnt = open ? cnt : '0;
    beats_g = &base_cnt ? base_cnt : base_cnt + 1'b1;
    close = ~ae[L] | lst[L];
    state_n = v[L] ? (close ? IDLE : OPEN) : state;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      ovf_acc <= 1'b0;
      cnt <= '0;
      bus.out_valid <= 1'b0;
      bus.out <= '0;
      bus.out_ovf <= 1'b0;
      bus.out_beats <= '0;
    end else begin
      bus.out_valid <= v[L] & close;
      if (v[L] & close) begin
        bus.out <= r;
        bus.out_ovf <= ovf_g;
        bus.out_beats <= beats_g;
        acc <= '0;
        ovf_acc <= 1'b0;
        cnt <= '0;
      end else if (v[L]) begin
        acc <= r;
        ovf_acc <= ovf_g;
        cnt <= beats_g;
      end
    end
  end
endmodule

// File: tb/tb_add_tree_acc.sv
// tb_add_tree_acc: drives unsigned and signed add_tree_acc instances with the same beats and checks both against a queued model
module tb_add_tree_acc;
  localparam int N = 4, BI = 8, BO = 12, CW = 8;
  typedef struct {logic [BO-1:0] o; logic f; logic [CW-1:0] b; int due;} exp_t;
  logic clk = 0, rst = 1;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  logic iv = 0, ae_i = 0, la = 0;
  logic [N*BI-1:0] din = '0;
  exp_t qu[$], qs[$];
  bit mo[2], mf[2];
  longint ma[2];
  int mc[2];
  logic [BO-1:0] ho[2];
  logic hf[2];
  logic [CW-1:0] hb[2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  add_tree_acc_if #(.NUMBER_INPUT(N), .BIT_INPUT(BI), .BIT_OUTPUT(BO), .CNT_W(CW)) bu ();
  add_tree_acc_if #(.NUMBER_INPUT(N), .BIT_INPUT(BI), .BIT_OUTPUT(BO), .CNT_W(CW)) bs ();
  assign bu.in_valid = iv;
  assign bu.in = din;
  assign bu.acc_en = ae_i;
  assign bu.in_last = la;
  assign bs.in_valid = iv;
  assign bs.in = din;
  assign bs.acc_en = ae_i;
  assign bs.in_last = la;
  add_tree_acc #(.NUMBER_INPUT(N), .BIT_INPUT(BI), .BIT_OUTPUT(BO), .SIGNED(0), .CNT_W(CW)) du (.clk(clk), .rst(rst), .bus(bu.slave));
  add_tree_acc #(.NUMBER_INPUT(N), .BIT_INPUT(BI), .BIT_OUTPUT(BO), .SIGNED(1), .CNT_W(CW)) ds (.clk(clk), .rst(rst), .bus(bs.slave));
  task automatic cmp(input string tag, input int s, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[signed=%0d] observed=%0d expected=%0d", tag, s, obs, exp);
    end
  endtask
  task automatic model(input int s, input logic [N*BI-1:0] dv, input bit a, input bit l);
    longint sum, r, hi, lo;
    bit c, f;
    int bt;
    exp_t e;
    sum = 0;
    for (int i = 0; i < N; i++)
      sum += s ? longint'($signed(dv[i*BI +: BI])) : longint'(dv[i*BI +: BI]);
    hi = s ? 2047 : 4095;
    lo = s ? -2048 : 0;
    r = (mo[s] ? ma[s] : 0) + sum;
    c = r > hi || r < lo;
    r = r > hi ? hi : r < lo ? lo : r;
    f = (mo[s] && mf[s]) || c;
    bt = (mo[s] ? mc[s] : 0) + 1;
    if (bt > 255) bt = 255;
    if (!a || l) begin
      e.o = r[BO-1:0];
      e.f = f;
      e.b = bt[CW-1:0];
      e.due = cyc + 3;
      if (s == 1) qs.push_back(e);
      else qu.push_back(e);
      mo[s] = 0; ma[s] = 0; mf[s] = 0; mc[s] = 0;
    end else begin
      mo[s] = 1; ma[s] = r; mf[s] = f; mc[s] = bt;
    end
  endtask
  task automatic beat(input logic [N*BI-1:0] dv, input bit a, input bit l);
    iv = 1; din = dv; ae_i = a; la = l;
    model(0, dv, a, l);
    model(1, dv, a, l);
    @(posedge clk); #1;
    iv = 0; din = '0; ae_i = 0; la = 0;
  endtask
  task automatic bubble(input int k);
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask
  task automatic rst_pulse();
    rst = 1; iv = 0;
    qu.delete(); qs.delete();
    for (int s = 0; s < 2; s++) begin
      mo[s] = 0; ma[s] = 0; mf[s] = 0; mc[s] = 0; ho[s] = '0; hf[s] = 0; hb[s] = '0;
    end
    @(posedge clk); #1;
    rst = 0;
  endtask
  function automatic logic [N*BI-1:0] pk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] e);
    return {e, c, b, a};
  endfunction
  task automatic chk(input int s, input logic ov, input logic [BO-1:0] o, input logic f, input logic [CW-1:0] b);
    exp_t e;
    int sz;
    sz = s == 1 ? qs.size() : qu.size();
    if (ov) begin
      cmp("pulse_expected", s, longint'(sz > 0), 1);
      if (sz > 0) begin
        e = s == 1 ? qs.pop_front() : qu.pop_front();
        cmp("latency", s, cyc, e.due);
        cmp("out", s, o, e.o);
        cmp("out_ovf", s, f, e.f);
        cmp("out_beats", s, b, e.b);
        ho[s] = e.o; hf[s] = e.f; hb[s] = e.b;
      end
    end else begin
      cmp("hold_out", s, o, ho[s]);
      cmp("hold_ovf", s, f, hf[s]);
      cmp("hold_beats", s, b, hb[s]);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    chk(0, bu.out_valid, bu.out, bu.out_ovf, bu.out_beats);
    chk(1, bs.out_valid, bs.out, bs.out_ovf, bs.out_beats);
  end
  initial begin
    rst_pulse();
    bubble(1);
    @(negedge clk);
    cmp("rst_out_valid", 0, bu.out_valid, 0);
    cmp("rst_out", 0, bu.out, 0);
    cmp("rst_out_beats", 1, bs.out_beats, 0);
    cmp("rst_out_ovf", 1, bs.out_ovf, 0);
    @(posedge clk); #1;
    beat(pk(1, 2, 3, 4), 0, 0);
    bubble(4);
    for (int n = 4; n <= 5; n++) begin
      for (int k = 1; k <= n; k++) beat(pk(255, 255, 255, 255), 1, k == n);
      bubble(4);
    end
    for (int n = 4; n <= 5; n++) begin
      for (int k = 1; k <= n; k++) begin
        beat(pk(255, 255, 255, 255), 1, k == n);
        if (k < n) bubble(k);
      end
      bubble(4);
    end
    for (int k = 1; k <= 5; k++) beat(pk(8'h80, 8'h80, 8'h80, 8'h80), 1, k == 5);
    beat(pk(8'h80, 8'h7f, 1, 0), 0, 0);
    bubble(4);
    beat(pk(1, 1, 1, 1), 1, 0);
    beat(pk(1, 1, 1, 1), 1, 0);
    rst_pulse();
    beat(pk(1, 1, 1, 1), 0, 0);
    bubble(4);
    beat(pk(1, 1, 1, 1), 1, 0);
    beat(pk(1, 1, 1, 1), 1, 0);
    beat(pk(2, 2, 2, 2), 0, 0);
    beat(pk(1, 1, 1, 1), 1, 1);
    beat(pk(3, 0, 0, 7), 0, 0);
    bubble(4);
    for (int k = 1; k <= 300; k++) beat(pk(0, 1, 0, 0), 1, k == 300);
    bubble(4);
    for (int k = 0; k < 40; k++) begin
      beat($urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) bubble($urandom_range(1, 3));
    end
    beat(pk(0, 0, 0, 0), 1, 1);
    bubble(6);
    cmp("drain", 0, qu.size(), 0);
    cmp("drain", 1, qs.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
